// File: rtl/uvmt_cv32e40x_sl_trigger_match_mem_seq.sv
// Scans the memory operations of one retired instruction through a shared trigger evaluator.
// Optional feature macro: UVMT_SL_TRIG_SEQ_FULL_SCAN_EN (visit every operation, build per-op hit map).
//
// state | meaning
// IDLE  | waiting for start_i; results hold
// SCAN  | presenting op_sel_o to the evaluator, one operation per cycle
// DONE  | done_o pulse; results valid
module uvmt_cv32e40x_sl_trigger_match_mem_seq #(
   parameter int NUM_TRIGGERS   = 2,
   parameter int MAX_MEM_ACCESS = 13,
   parameter int OP_W           = $clog2(MAX_MEM_ACCESS + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic [OP_W-1:0]           num_ops_i,
   input  logic                      flush_i,
   output logic [OP_W-1:0]           op_sel_o,
   input  logic [NUM_TRIGGERS-1:0]   op_match_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [NUM_TRIGGERS-1:0]   match_o,
   output logic [OP_W-1:0]           match_op_o,
   output logic                      any_match_o,
   output logic                      clamp_o,
   output logic                      overrun_o,
   output logic [MAX_MEM_ACCESS-1:0] op_hit_map_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [OP_W-1:0]         idx_q, idx_d;
   logic [OP_W-1:0]         n_q, n_d;
   logic [OP_W-1:0]         match_op_q, match_op_d;
   logic [NUM_TRIGGERS-1:0] match_q, match_d;
   logic                    clamp_q, clamp_d;
   logic                    overrun_q, overrun_d;
   logic                    over_max;
   logic [OP_W-1:0]         n_clamped;
   logic                    hit;
   logic                    last_op;
   logic                    flush_now;

   always_comb begin
      over_max   = num_ops_i > OP_W'(MAX_MEM_ACCESS);
      n_clamped  = over_max ? OP_W'(MAX_MEM_ACCESS) : num_ops_i;
      hit        = |op_match_i;
      last_op    = idx_q == (n_q - OP_W'(1));
      flush_now  = flush_i && (state_q != IDLE);

      state_d    = state_q;
      idx_d      = idx_q;
      n_d        = n_q;
      match_d    = match_q;
      match_op_d = match_op_q;
      clamp_d    = 1'b0;
      overrun_d  = start_i && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (start_i) begin
               n_d        = n_clamped;
               clamp_d    = over_max;
               match_d    = '0;
               match_op_d = '0;
               idx_d      = '0;
               state_d    = (n_clamped != '0) ? SCAN : DONE;
            end
         end
         SCAN: begin
`ifdef UVMT_SL_TRIG_SEQ_FULL_SCAN_EN
            // Later hits are recorded in the map only; the first hit stays latched.
            if (hit && !(|match_q)) begin
               match_d    = op_match_i;
               match_op_d = idx_q;
            end
            if (last_op) begin
               state_d = DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + OP_W'(1);
            end
`else
            if (hit) begin
               match_d    = op_match_i;
               match_op_d = idx_q;
               state_d    = DONE;
               idx_d      = '0;
            end else if (last_op) begin
               state_d = DONE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + OP_W'(1);
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase

      if (flush_now) begin
         state_d    = IDLE;
         idx_d      = '0;
         match_d    = '0;
         match_op_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         n_q        <= '0;
         match_q    <= '0;
         match_op_q <= '0;
         clamp_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         n_q        <= n_d;
         match_q    <= match_d;
         match_op_q <= match_op_d;
         clamp_q    <= clamp_d;
         overrun_q  <= overrun_d;
      end
   end

`ifdef UVMT_SL_TRIG_SEQ_FULL_SCAN_EN
   logic [MAX_MEM_ACCESS-1:0] map_q, map_d;

   always_comb begin
      map_d = map_q;
      if (flush_now || (state_q == IDLE && start_i)) begin
         map_d = '0;
      end else if (state_q == SCAN) begin
         for (int k = 0; k < MAX_MEM_ACCESS; k++) begin
            if (hit && idx_q == OP_W'(k)) begin
               map_d[k] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         map_q <= '0;
      end else begin
         map_q <= map_d;
      end
   end

   assign op_hit_map_o = map_q;
`else
   assign op_hit_map_o = '0;
`endif

   // idx_q is forced to zero on every exit from SCAN, so it can drive op_sel_o directly.
   assign op_sel_o    = idx_q;
   assign busy_o      = state_q != IDLE;
   assign done_o      = state_q == DONE;
   assign match_o     = match_q;
   assign match_op_o  = match_op_q;
   assign any_match_o = |match_q;
   assign clamp_o     = clamp_q;
   assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uvmt_cv32e40x_sl_trigger_match_mem_seq.sv
// Self-checking bench: a model fills a scoreboard on each start, entries are checked on done_o.
module tb_uvmt_cv32e40x_sl_trigger_match_mem_seq;

`ifdef UVMT_SL_TRIG_SEQ_FULL_SCAN_EN
   localparam bit FULL = 1'b1;
`else
   localparam bit FULL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [3:0]  num_ops = '0;
   logic [3:0]  op_sel;
   logic [1:0]  op_match;
   logic        busy, done, any_match, clamp, overrun;
   logic [1:0]  match;
   logic [3:0]  match_op;
   logic [12:0] hit_map;

   logic [1:0]  hit_vec [16];

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          done_cyc;
      logic [1:0]  match;
      logic [3:0]  match_op;
      logic [12:0] map;
   } exp_t;

   exp_t sb[$];

   uvmt_cv32e40x_sl_trigger_match_mem_seq dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .num_ops_i    (num_ops),
      .flush_i      (flush),
      .op_sel_o     (op_sel),
      .op_match_i   (op_match),
      .busy_o       (busy),
      .done_o       (done),
      .match_o      (match),
      .match_op_o   (match_op),
      .any_match_o  (any_match),
      .clamp_o      (clamp),
      .overrun_o    (overrun),
      .op_hit_map_o (hit_map)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always_comb op_match = hit_vec[op_sel];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_hits();
      for (int i = 0; i < 16; i++) hit_vec[i] = 2'b00;
   endtask

   // Reference model: expected completion cycle and results for a scan started in cycle c.
   task automatic push_exp(input int c, input int n);
      exp_t e;
      int   nn;
      int   first;
      nn = (n > 13) ? 13 : n;
      first = -1;
      e.match = '0;
      e.match_op = '0;
      e.map = '0;
      for (int k = 0; k < nn; k++) begin
         if (hit_vec[k] != 2'b00) begin
            if (FULL) e.map[k] = 1'b1;
            if (first < 0) begin
               first = k;
               e.match = hit_vec[k];
               e.match_op = 4'(k);
            end
         end
      end
      if (nn == 0) e.done_cyc = c + 1;
      else if (!FULL && first >= 0) e.done_cyc = c + 2 + first;
      else e.done_cyc = c + 1 + nn;
      sb.push_back(e);
   endtask

   task automatic do_start(input int n, output int c);
      @(posedge clk);
      #1;
      start = 1'b1;
      num_ops = 4'(n);
      c = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit got, output int dcyc, output int max_sel);
      got = 1'b0;
      dcyc = -1;
      max_sel = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (int'(op_sel) > max_sel) max_sel = int'(op_sel);
         if (done) begin
            got = 1'b1;
            dcyc = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int c, dcyc, ms;
      bit got, found;
      exp_t e;
      #12;
      checks++;
      if ({busy, done, op_sel, match, match_op, any_match, clamp, overrun, hit_map} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b sel=%0d match=%b op=%0d any=%b clamp=%b ovr=%b map=%h, want all 0",
                  busy, done, op_sel, match, match_op, any_match, clamp, overrun, hit_map);
      end
      @(negedge clk);
      rst_n = 1'b1;
      clear_hits();
      do_start(13, c);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (op_sel == 4'd5) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL reset_mid_scan_reach: op_sel never reached 5");
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, op_sel, match, match_op, any_match, clamp, overrun, hit_map} !== '0) begin
         errors++;
         $display("FAIL reset_mid_scan_outputs: got busy=%b done=%b sel=%0d match=%b, want all 0", busy, done, op_sel, match);
      end
      @(negedge clk);
      rst_n = 1'b1;
      hit_vec[0] = 2'b10;
      do_start(3, c);
      push_exp(c, 3);
      wait_done(20, got, dcyc, ms);
      e = sb.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL reset_restart_done: done_o never pulsed");
      end else if (dcyc !== e.done_cyc || match !== e.match || match_op !== e.match_op || hit_map !== e.map) begin
         errors++;
         $display("FAIL reset_restart_result: got cyc=%0d match=%b op=%0d map=%h, want cyc=%0d match=%b op=%0d map=%h",
                  dcyc, match, match_op, hit_map, e.done_cyc, e.match, e.match_op, e.map);
      end
   endtask

   task automatic test_single_hit();
      int c, dcyc, ms;
      bit got;
      exp_t e;
      clear_hits();
      hit_vec[4] = 2'b10;
      do_start(13, c);
      push_exp(c, 13);
      wait_done(20, got, dcyc, ms);
      e = sb.pop_front();
      checks++;
      if (!got || dcyc !== e.done_cyc) begin
         errors++;
         $display("FAIL single_hit_timing: got done cycle %0d, want %0d", dcyc, e.done_cyc);
      end
      checks++;
      if (match !== e.match || match_op !== e.match_op || any_match !== 1'b1 || hit_map !== e.map) begin
         errors++;
         $display("FAIL single_hit_result: got match=%b op=%0d any=%b map=%h, want match=%b op=%0d any=1 map=%h",
                  match, match_op, any_match, hit_map, e.match, e.match_op, e.map);
      end
   endtask

   task automatic test_zero_ops();
      int c, dcyc, ms;
      bit got;
      exp_t e;
      clear_hits();
      hit_vec[0] = 2'b11;
      do_start(0, c);
      push_exp(c, 0);
      wait_done(20, got, dcyc, ms);
      e = sb.pop_front();
      checks++;
      if (!got || dcyc !== e.done_cyc || any_match !== 1'b0 || match !== 2'b00) begin
         errors++;
         $display("FAIL zero_ops: got cyc=%0d any=%b match=%b, want cyc=%0d any=0 match=00", dcyc, any_match, match, e.done_cyc);
      end
      checks++;
      if (ms !== 0) begin
         errors++;
         $display("FAIL zero_ops_sel: got max op_sel %0d, want 0", ms);
      end
   endtask

   task automatic test_clamp();
      int c, dcyc, ms;
      bit got;
      exp_t e;
      clear_hits();
      do_start(15, c);
      checks++;
      if (clamp !== 1'b1) begin
         errors++;
         $display("FAIL clamp_pulse: got clamp_o=%b, want 1", clamp);
      end
      push_exp(c, 15);
      wait_done(30, got, dcyc, ms);
      e = sb.pop_front();
      checks++;
      if (!got || dcyc !== e.done_cyc || ms !== 12 || any_match !== 1'b0) begin
         errors++;
         $display("FAIL clamp_scan: got cyc=%0d max_sel=%0d any=%b, want cyc=%0d max_sel=12 any=0", dcyc, ms, any_match, e.done_cyc);
      end
   endtask

   task automatic test_first_hit();
      int c, dcyc, ms;
      bit got;
      exp_t e;
      clear_hits();
      hit_vec[2] = 2'b01;
      hit_vec[7] = 2'b10;
      do_start(13, c);
      push_exp(c, 13);
      wait_done(20, got, dcyc, ms);
      e = sb.pop_front();
      checks++;
      if (!got || dcyc !== e.done_cyc || match !== e.match || match_op !== e.match_op || hit_map !== e.map) begin
         errors++;
         $display("FAIL first_hit: got cyc=%0d match=%b op=%0d map=%h, want cyc=%0d match=%b op=%0d map=%h",
                  dcyc, match, match_op, hit_map, e.done_cyc, e.match, e.match_op, e.map);
      end
   endtask

   task automatic test_overrun();
      int c, dcyc, ms, extra;
      bit got;
      exp_t e;
      clear_hits();
      hit_vec[6] = 2'b01;
      do_start(13, c);
      push_exp(c, 13);
      @(posedge clk);
      #1;
      start = 1'b1;
      num_ops = 4'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_scan: got overrun_o=%b, want 1", overrun);
      end
      wait_done(20, got, dcyc, ms);
      e = sb.pop_front();
      checks++;
      if (!got || dcyc !== e.done_cyc || match !== e.match || match_op !== e.match_op) begin
         errors++;
         $display("FAIL overrun_result: got cyc=%0d match=%b op=%0d, want cyc=%0d match=%b op=%0d",
                  dcyc, match, match_op, e.done_cyc, e.match, e.match_op);
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (overrun !== 1'b1 || busy !== 1'b0 || match_op !== e.match_op || match !== e.match) begin
         errors++;
         $display("FAIL overrun_done: got ovr=%b busy=%b match=%b op=%0d, want ovr=1 busy=0 match=%b op=%0d",
                  overrun, busy, match, match_op, e.match, e.match_op);
      end
      extra = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (busy || done) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL overrun_no_second_scan: got %0d busy/done cycles, want 0", extra);
      end
   endtask

   task automatic test_flush();
      int c, dcyc, ms;
      bit got, found;
      exp_t e;
      clear_hits();
      hit_vec[10] = 2'b11;
      do_start(13, c);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (op_sel == 4'd3) found = 1'b1;
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checks++;
      if (!found || busy !== 1'b0 || done !== 1'b0 || op_sel !== 4'd0 || match !== 2'b00 || match_op !== 4'd0 || any_match !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle: got reached=%b busy=%b done=%b sel=%0d match=%b op=%0d any=%b, want reached=1 and all 0",
                  found, busy, done, op_sel, match, match_op, any_match);
      end
      clear_hits();
      hit_vec[1] = 2'b01;
      start = 1'b1;
      num_ops = 4'd2;
      c = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      push_exp(c, 2);
      wait_done(20, got, dcyc, ms);
      e = sb.pop_front();
      checks++;
      if (!got || dcyc !== e.done_cyc || match !== e.match || match_op !== e.match_op) begin
         errors++;
         $display("FAIL flush_restart: got cyc=%0d match=%b op=%0d, want cyc=%0d match=%b op=%0d",
                  dcyc, match, match_op, e.done_cyc, e.match, e.match_op);
      end
   endtask

   task automatic test_back_to_back();
      int c, dcyc, ms, n;
      bit got;
      exp_t e;
      for (int it = 0; it < 6; it++) begin
         clear_hits();
         n = $urandom_range(1, 15);
         for (int k = 0; k < 13; k++) begin
            if ($urandom_range(0, 7) == 0) hit_vec[k] = 2'($urandom_range(1, 3));
         end
         do_start(n, c);
         push_exp(c, n);
         wait_done(30, got, dcyc, ms);
         e = sb.pop_front();
         checks++;
         if (!got || dcyc !== e.done_cyc || match !== e.match || match_op !== e.match_op || hit_map !== e.map) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got cyc=%0d match=%b op=%0d map=%h, want cyc=%0d match=%b op=%0d map=%h",
                     it, dcyc, match, match_op, hit_map, e.done_cyc, e.match, e.match_op, e.map);
         end
      end
   endtask

   initial begin
      clear_hits();
      test_reset();
      test_single_hit();
      test_zero_ops();
      test_clamp();
      test_first_hit();
      test_overrun();
      test_flush();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
